// File: rtl/ntt16_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// ntt16_pkg - shared types and index helpers for the NTT16 sequencer
// rev 1.0
//------------------------------------------------------------------
package ntt16_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Upper butterfly index: group base (g * 2 * half) plus offset j within the group.
  function automatic logic [3:0] idx_u(input logic [1:0] stage, input logic [2:0] cnt);
    logic [3:0] mask;
    logic [3:0] j;
    logic [3:0] g;
    mask = (4'd1 << stage) - 4'd1;
    j    = {1'b0, cnt} & mask;
    g    = {1'b0, cnt} >> stage;
    return ((g << stage) << 1) + j;
  endfunction

  function automatic logic [3:0] idx_v(input logic [1:0] stage, input logic [2:0] cnt);
    return idx_u(stage, cnt) + (4'd1 << stage);
  endfunction

  function automatic logic [2:0] tw_idx(input logic [1:0] stage, input logic [2:0] cnt);
    logic [2:0] j;
    j = cnt & 3'((4'd1 << stage) - 4'd1);
    return j << (2'd3 - stage);
  endfunction

endpackage : ntt16_pkg
`default_nettype wire

// File: rtl/ntt16_stage_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------
// ntt16_stage_sequencer_if - stream-in, butterfly and stream-out bundle
// rev 1.0
//------------------------------------------------------------------
interface ntt16_stage_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] bf_u;
  logic [DATA_WIDTH-1:0] bf_v;
  logic [DATA_WIDTH-1:0] bf_twiddle;
  logic [DATA_WIDTH-1:0] bf_sum;
  logic [DATA_WIDTH-1:0] bf_diff;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  // master is the sequencer; slave is the surrounding source, sink and butterfly.
  modport master (
    input  in_valid, in_data, bf_sum, bf_diff, out_ready,
    output in_ready, bf_u, bf_v, bf_twiddle, out_valid, out_data, out_last, busy
  );

  modport slave (
    output in_valid, in_data, bf_sum, bf_diff, out_ready,
    input  in_ready, bf_u, bf_v, bf_twiddle, out_valid, out_data, out_last, busy
  );

endinterface : ntt16_stage_sequencer_if
`default_nettype wire

// File: rtl/ntt16_twiddle_rom.sv
`default_nettype none
//------------------------------------------------------------------
// ntt16_twiddle_rom - 8-entry ROOT^i mod MODULUS table, combinational read
// rev 1.0
//------------------------------------------------------------------
module ntt16_twiddle_rom #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODULUS    = 17,
  parameter int unsigned ROOT       = 3
) (
  input  logic [2:0]            addr_i,
  output logic [DATA_WIDTH-1:0] twiddle_o
);

  function automatic logic [DATA_WIDTH-1:0] pow_mod(input int e);
    logic [63:0] acc;
    acc = 64'(1) % 64'(MODULUS);
    for (int k = 0; k < e; k++) begin
      acc = (acc * 64'(ROOT)) % 64'(MODULUS);
    end
    return acc[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] tw_table [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tw
      localparam logic [DATA_WIDTH-1:0] c_tw = pow_mod(gi);
      assign tw_table[gi] = c_tw;
    end
  endgenerate

  assign twiddle_o = tw_table[addr_i];

endmodule : ntt16_twiddle_rom
`default_nettype wire

// File: rtl/ntt16_stage_sequencer.sv
`default_nettype none
//------------------------------------------------------------------
// ntt16_stage_sequencer - load / 4-stage in-place NTT / drain controller
// rev 1.0
//------------------------------------------------------------------
module ntt16_stage_sequencer
  import ntt16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODULUS    = 17,
  parameter int unsigned ROOT       = 3
) (
  input logic                      clk,
  input logic                      rst,
  ntt16_stage_sequencer_if.master  seq_io
);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
  logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
  logic [1:0]       stage_q, stage_d;
  logic [2:0]       bf_cnt_q, bf_cnt_d;

  logic [DATA_WIDTH-1:0] rf_q [N];

  logic [3:0]            iu;
  logic [3:0]            iv;
  logic [2:0]            tw_addr;
  logic [DATA_WIDTH-1:0] twiddle;
  logic                  load_fire;
  logic                  compute_we;

  assign iu      = idx_u(stage_q, bf_cnt_q);
  assign iv      = idx_v(stage_q, bf_cnt_q);
  assign tw_addr = tw_idx(stage_q, bf_cnt_q);

  ntt16_twiddle_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS),
    .ROOT       (ROOT)
  ) u_twiddle_rom (
    .addr_i    (tw_addr),
    .twiddle_o (twiddle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      out_cnt_q  <= '0;
      stage_q    <= '0;
      bf_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q  <= out_cnt_d;
      stage_q    <= stage_d;
      bf_cnt_q   <= bf_cnt_d;
    end
  end

  // Register file carries no reset; stale contents are always overwritten by a full load.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      rf_q[bitrev4(load_cnt_q)] <= seq_io.in_data;
    end
    if (compute_we) begin
      rf_q[iu] <= seq_io.bf_sum;
      rf_q[iv] <= seq_io.bf_diff;
    end
  end

  always_comb begin
    state_d           = state_q;
    load_cnt_d        = load_cnt_q;
    out_cnt_d         = out_cnt_q;
    stage_d           = stage_q;
    bf_cnt_d          = bf_cnt_q;
    load_fire         = 1'b0;
    compute_we        = 1'b0;
    seq_io.in_ready   = 1'b0;
    seq_io.out_valid  = 1'b0;
    seq_io.out_data   = '0;
    seq_io.out_last   = 1'b0;
    seq_io.busy       = 1'b0;
    seq_io.bf_u       = '0;
    seq_io.bf_v       = '0;
    seq_io.bf_twiddle = '0;

    if (!rst) begin
      case (state_q)
        LOAD: begin
          seq_io.in_ready = 1'b1;
          if (seq_io.in_valid) begin
            load_fire  = 1'b1;
            load_cnt_d = load_cnt_q + 4'd1;
            if (load_cnt_q == 4'(N - 1)) begin
              state_d = COMPUTE;
            end
          end
        end
        COMPUTE: begin
          seq_io.busy       = 1'b1;
          compute_we        = 1'b1;
          seq_io.bf_u       = rf_q[iu];
          seq_io.bf_v       = rf_q[iv];
          seq_io.bf_twiddle = twiddle;
          bf_cnt_d          = bf_cnt_q + 3'd1;
          if (bf_cnt_q == 3'd7) begin
            stage_d = stage_q + 2'd1;
            if (stage_q == 2'd3) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          seq_io.busy      = 1'b1;
          seq_io.out_valid = 1'b1;
          seq_io.out_data  = rf_q[out_cnt_q];
          seq_io.out_last  = (out_cnt_q == 4'(N - 1));
          if (seq_io.out_ready) begin
            out_cnt_d = out_cnt_q + 4'd1;
            if (out_cnt_q == 4'(N - 1)) begin
              state_d = LOAD;
            end
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

endmodule : ntt16_stage_sequencer
`default_nettype wire

// File: tb/tb_ntt16_stage_sequencer.sv
`default_nettype none
//------------------------------------------------------------------
// tb_ntt16_stage_sequencer - directed vectors against a modular butterfly model
// rev 1.0
//------------------------------------------------------------------
module tb_ntt16_stage_sequencer;

  localparam int DW = 16;
  localparam int M  = 17;

  typedef logic [15:0] vec_t [16];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ntt16_stage_sequencer_if #(.DATA_WIDTH(DW)) sq ();

  ntt16_stage_sequencer #(
    .DATA_WIDTH (DW),
    .MODULUS    (M),
    .ROOT       (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (sq)
  );

  int bf_p;
  always_comb begin
    bf_p       = (int'(sq.bf_v) * int'(sq.bf_twiddle)) % M;
    sq.bf_sum  = 16'((int'(sq.bf_u) + bf_p) % M);
    sq.bf_diff = 16'((int'(sq.bf_u) + M - bf_p) % M);
  end

  int n_cmp = 0;
  int n_err = 0;

  vec_t v_delta, v_x1, v_ones, e_all1, e_ones;
  vec_t e_x1 = '{16'd1, 16'd3, 16'd9, 16'd10, 16'd13, 16'd5, 16'd15, 16'd11,
                 16'd16, 16'd14, 16'd8, 16'd7, 16'd4, 16'd12, 16'd2, 16'd6};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load16(input vec_t v, input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        sq.in_valid = 1'b0;
      end else begin
        sq.in_valid = 1'b1;
        sq.in_data  = v[i];
        if (sq.in_ready) i++;
      end
    end
    chk("load_accepts", i, 16);
  endtask

  task automatic run_out(input vec_t exp, input bit stalls);
    int lat;
    int ccnt;
    int rdy_bad;
    int k;
    int guard;
    lat = 0;
    ccnt = 0;
    rdy_bad = 0;
    sq.out_ready = 1'b0;
    do begin
      @(negedge clk);
      sq.in_valid = 1'b0;
      lat++;
      if (sq.in_ready) rdy_bad++;
      if (sq.busy && !sq.out_valid) ccnt++;
    end while (!sq.out_valid && lat < 200);
    chk("latency", lat, 33);
    chk("compute_cycles", ccnt, 32);

    k = 0;
    guard = 0;
    while (k < 16 && guard < 600) begin
      sq.out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      chk("out_valid", sq.out_valid, 1);
      chk("out_data", sq.out_data, exp[k]);
      chk("out_last", sq.out_last, k == 15);
      if (sq.in_ready) rdy_bad++;
      if (sq.out_ready) k++;
      @(negedge clk);
      guard++;
    end
    sq.out_ready = 1'b0;
    chk("beats", k, 16);
    chk("in_ready_while_busy", rdy_bad, 0);
    chk("post_out_valid", sq.out_valid, 0);
    chk("post_busy", sq.busy, 0);
    chk("post_in_ready", sq.in_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      v_delta[i] = (i == 0) ? 16'd1 : 16'd0;
      v_x1[i]    = (i == 1) ? 16'd1 : 16'd0;
      v_ones[i]  = 16'd1;
      e_all1[i]  = 16'd1;
      e_ones[i]  = (i == 0) ? 16'd16 : 16'd0;
    end

    rst          = 1'b1;
    sq.in_valid  = 1'b0;
    sq.in_data   = '0;
    sq.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", sq.in_ready, 0);
    chk("rst_out_valid", sq.out_valid, 0);
    chk("rst_out_last", sq.out_last, 0);
    chk("rst_busy", sq.busy, 0);
    chk("rst_bf_u", sq.bf_u, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", sq.in_ready, 1);
    chk("idle_bf_twiddle", sq.bf_twiddle, 0);

    load16(v_delta, 1'b0);
    run_out(e_all1, 1'b0);

    // Back-to-back: the next load begins right after the previous drain.
    load16(v_x1, 1'b0);
    run_out(e_x1, 1'b0);

    load16(v_ones, 1'b0);
    run_out(e_ones, 1'b0);

    load16(v_x1, 1'b1);
    run_out(e_x1, 1'b1);

    // Abort a transform during stage 2 of COMPUTE.
    load16(v_x1, 1'b0);
    repeat (20) begin
      @(negedge clk);
      sq.in_valid = 1'b0;
    end
    chk("mid_busy", sq.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", sq.in_ready, 0);
    chk("abort_out_valid", sq.out_valid, 0);
    chk("abort_busy", sq.busy, 0);
    chk("abort_out_last", sq.out_last, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_exit_in_ready", sq.in_ready, 1);
    chk("abort_exit_busy", sq.busy, 0);
    load16(v_delta, 1'b0);
    run_out(e_all1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ntt16_stage_sequencer
`default_nettype wire

// File: doc/ntt16_stage_sequencer.md
Name: ntt16_stage_sequencer

Overview:
- Control and data-storage stage that feeds the NTT butterfly unit and consumes its results.
- Accepts 16 coefficients as a stream and stores them in bit-reversed order in a 16-entry register file.
- Runs a 4-stage radix-2 Cooley-Tukey forward NTT with one butterfly per cycle, using an externally instantiated butterfly.
- Streams the 16 transformed coefficients out in natural order.

Parameters:
- DATA_WIDTH, 16, coefficient/twiddle width.
- MODULUS, 17, prime modulus. Same value as the butterfly instance.
- ROOT, 3, primitive 16th root of unity mod MODULUS. Used to build the twiddle table.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  sequencer can accept a coefficient.
- in_data  in  DATA_WIDTH  input coefficient. Must be < MODULUS; not checked.
- bf_u  out  DATA_WIDTH  butterfly u operand.
- bf_v  out  DATA_WIDTH  butterfly v operand.
- bf_twiddle  out  DATA_WIDTH  butterfly twiddle operand.
- bf_sum  in  DATA_WIDTH  butterfly (u+v*w) mod M. Combinational, same cycle.
- bf_diff  in  DATA_WIDTH  butterfly (u-v*w) mod M. Combinational, same cycle.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  transformed coefficient X[k].
- out_last  out  1  high with X[15].
- busy  out  1  high in COMPUTE and DRAIN.

Behaviour:
- States: LOAD, COMPUTE, DRAIN.
- Reset:
  - state=LOAD; load_cnt, stage, bf_cnt and out_cnt cleared to 0.
  - Register file is not cleared.
  - While rst=1: in_ready=0, out_valid=0, out_last=0, busy=0.
  - A reset at any point aborts the transform and discards partial data. The first cycle after reset is in LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, write in_data to reg[bitrev4(load_cnt)], then load_cnt++.
  - After the 16th accept (load_cnt 15 -> 0), go to COMPUTE next cycle.
- COMPUTE:
  - in_ready=0. No stall, exactly 32 cycles.
  - Each cycle: half = 1<<stage, j = bf_cnt mod half, g = bf_cnt / half.
  - iu = g*2*half + j; iv = iu + half.
  - bf_u = reg[iu], bf_v = reg[iv], bf_twiddle = TW[j << (3-stage)], where TW[i] = ROOT^i mod MODULUS for i = 0..7.
  - Same clock edge: reg[iu] <= bf_sum, reg[iv] <= bf_diff.
  - bf_cnt increments 0..7; when it wraps, stage increments.
  - After stage 3, bf_cnt 7, go to DRAIN.
  - Outside COMPUTE, bf_* outputs are 0.
- DRAIN:
  - out_valid=1, out_data = reg[out_cnt], out_last = (out_cnt==15).
  - On out_valid&out_ready, out_cnt++.
  - If out_ready=0, data is held stable.
  - After the out_last handshake, go to LOAD next cycle.
- Latency: first out_valid comes 33 cycles after the 16th input accept (32 compute cycles plus the transition).
- Throughput: one 16-point transform per 16+32+16 cycles minimum. No overlap between load and drain.
- Arithmetic: all modular arithmetic is done in the butterfly. The sequencer only routes values and never widens them.
- Index arithmetic uses 4-bit unsigned values.

Decomposition:
- Package ntt16_pkg contains:
  - N=16, LOG2N=4.
  - State enum {LOAD, COMPUTE, DRAIN}.
  - bitrev4 function.
  - Twiddle-index and iu/iv index functions.
- Sub-module ntt16_twiddle_rom (parameters DATA_WIDTH, MODULUS, ROOT; 3-bit address -> twiddle):
  - Table is computed at elaboration by repeated modular multiplication.
  - Combinational read.

Test Plan:
- Delta input [1,0,...,0], M=17, ROOT=3 -> all 16 outputs = 1; out_last on 16th beat; busy falls after it.
- x[1]=1, all other inputs 0 -> outputs in order 1,3,9,10,13,5,15,11,16,14,8,7,4,12,2,6.
- All-ones input -> X[0]=16, X[1..15]=0. Confirm exactly 32 COMPUTE cycles and the 33-cycle latency.
- Random in_valid gaps and random out_ready stalls on the x[1]=1 vector:
  - Same outputs as the unstalled run.
  - out_data stable while out_ready=0.
  - in_ready=0 throughout COMPUTE and DRAIN.
- Assert rst in mid-COMPUTE (stage 2), then run a delta transform -> outputs all 1; no beats from the aborted transform appear.
- Two back-to-back transforms (delta, then x[1]=1) -> second transform correct; in_ready rises the cycle after the first transform's out_last handshake.
